fpu_req_scheduler: RTL and testbench

//  Shares one fpu instance between N_REQ requesters. Grants one request at a time and drives the

---
 rtl/fpu_sched_pkg.sv | 20 ++
 rtl/fpu_rr_arbiter.sv | 56 +++++
 rtl/fpu_req_scheduler.sv | 114 +++++++++++
 tb/tb_fpu_req_scheduler.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fpu_sched_pkg.sv
// ---------------------------------------------------------------------------
// fpu_sched_pkg : shared types and widths for the fpu request scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fpu_sched_pkg;

  localparam int DATA_W   = 32;
  localparam int STATUS_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/fpu_rr_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_rr_arbiter : combinational grant picker; FPU_SCHED_ROUND_ROBIN_EN selects
// round-robin from last_grant+1, otherwise lowest index wins.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fpu_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             grant_valid
);

`ifdef FPU_SCHED_ROUND_ROBIN_EN
  int idx;

  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    idx         = 0;
    // Offsets 1..N_REQ visit every requester once, ending at last_grant itself.
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(last_grant) + i) % N_REQ;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
    if (grant_valid) grant[grant_id] = 1'b1;
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_valid && req[i]) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'(i);
      end
    end
    if (grant_valid) grant[grant_id] = 1'b1;
  end
`endif

endmodule

`default_nettype wire

// File: rtl/fpu_req_scheduler.sv
// ---------------------------------------------------------------------------
// fpu_req_scheduler : shares one fpu between N_REQ requesters, one op at a time.
// Option macro: FPU_SCHED_ROUND_ROBIN_EN (round-robin arbitration).  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fpu_req_scheduler
  import fpu_sched_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int FPU_LATENCY = 4,
  parameter int ID_W        = $clog2(N_REQ)
) (
  input  logic                    clock100KHz,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid_in,
  output logic [N_REQ-1:0]        req_ready_out,
  input  logic [N_REQ*DATA_W-1:0] req_op_a_in,
  input  logic [N_REQ*DATA_W-1:0] req_op_b_in,
  output logic [N_REQ-1:0]        rsp_valid_out,
  input  logic [N_REQ-1:0]        rsp_ready_in,
  output logic [DATA_W-1:0]       rsp_data_out,
  output logic [STATUS_W-1:0]     rsp_status_out,
  output logic                    rsp_flags_out,
  output logic [DATA_W-1:0]       fpu_op_a_out,
  output logic [DATA_W-1:0]       fpu_op_b_out,
  input  logic [DATA_W-1:0]       fpu_data_in,
  input  logic [STATUS_W-1:0]     fpu_status_in,
  input  logic                    fpu_flags_in,
  output logic                    busy_out,
  output logic [ID_W-1:0]         grant_id_out
);

  localparam int               CNT_W      = (FPU_LATENCY > 1) ? $clog2(FPU_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(FPU_LATENCY - 1);
  localparam logic [ID_W-1:0]  LAST_RESET = ID_W'(N_REQ - 1);

  sched_state_t     state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [ID_W-1:0]  last_grant;
  logic [N_REQ-1:0] arb_grant;
  logic [ID_W-1:0]  arb_id;
  logic             arb_valid;
  logic             accept;

  fpu_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req         (req_valid_in),
    .last_grant  (last_grant),
    .grant       (arb_grant),
    .grant_id    (arb_id),
    .grant_valid (arb_valid)
  );

  // Ready is withheld while reset is asserted so no handshake appears accepted.
  assign accept        = (state == IDLE) && reset && arb_valid;
  assign req_ready_out = accept ? arb_grant : '0;
  assign busy_out      = (state != IDLE);

  always_comb begin
    rsp_valid_out = '0;
    if (state == RESPOND) rsp_valid_out[grant_id_out] = 1'b1;
  end

  always_ff @(posedge clock100KHz) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (arb_valid)                  state_next = WAIT;
      WAIT:    if (cnt == '0)                  state_next = RESPOND;
      RESPOND: if (rsp_ready_in[grant_id_out]) state_next = IDLE;
      default:                                 state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock100KHz) begin
    if (!reset) begin
      cnt            <= '0;
      last_grant     <= LAST_RESET;
      grant_id_out   <= '0;
      fpu_op_a_out   <= '0;
      fpu_op_b_out   <= '0;
      rsp_data_out   <= '0;
      rsp_status_out <= '0;
      rsp_flags_out  <= 1'b0;
    end else begin
      if (accept) begin
        fpu_op_a_out <= req_op_a_in[arb_id*DATA_W +: DATA_W];
        fpu_op_b_out <= req_op_b_in[arb_id*DATA_W +: DATA_W];
        grant_id_out <= arb_id;
        last_grant   <= arb_id;
        cnt          <= CNT_LOAD;
      end
      if (state == WAIT) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          rsp_data_out   <= fpu_data_in;
          rsp_status_out <= fpu_status_in;
          rsp_flags_out  <= fpu_flags_in;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fpu_req_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fpu_req_scheduler : directed bench with a pipelined fpu stand-in.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fpu_req_scheduler;

  localparam int N = 2;
  localparam int L = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance (latency L)
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*32-1:0] op_a, op_b;
  logic [31:0]     rsp_data, fpu_a, fpu_b, fpu_data;
  logic [3:0]      rsp_status, fpu_status;
  logic            rsp_flags, fpu_flags, busy;
  logic [0:0]      gid;

  // Second instance with latency 1
  logic [N-1:0]    b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
  logic [N*32-1:0] b_op_a, b_op_b;
  logic [31:0]     b_rsp_data, b_fpu_a, b_fpu_b, b_fpu_data;
  logic [3:0]      b_rsp_status, b_fpu_status;
  logic            b_rsp_flags, b_fpu_flags, b_busy;
  logic [0:0]      b_gid;

  int pass_cnt = 0;
  int total    = 0;

  fpu_req_scheduler #(.N_REQ(N), .FPU_LATENCY(L)) dut (
    .clock100KHz(clk), .reset(rst_n),
    .req_valid_in(req_valid), .req_ready_out(req_ready),
    .req_op_a_in(op_a), .req_op_b_in(op_b),
    .rsp_valid_out(rsp_valid), .rsp_ready_in(rsp_ready),
    .rsp_data_out(rsp_data), .rsp_status_out(rsp_status), .rsp_flags_out(rsp_flags),
    .fpu_op_a_out(fpu_a), .fpu_op_b_out(fpu_b),
    .fpu_data_in(fpu_data), .fpu_status_in(fpu_status), .fpu_flags_in(fpu_flags),
    .busy_out(busy), .grant_id_out(gid)
  );

  fpu_req_scheduler #(.N_REQ(N), .FPU_LATENCY(1)) dut1 (
    .clock100KHz(clk), .reset(rst_n),
    .req_valid_in(b_req_valid), .req_ready_out(b_req_ready),
    .req_op_a_in(b_op_a), .req_op_b_in(b_op_b),
    .rsp_valid_out(b_rsp_valid), .rsp_ready_in(b_rsp_ready),
    .rsp_data_out(b_rsp_data), .rsp_status_out(b_rsp_status), .rsp_flags_out(b_rsp_flags),
    .fpu_op_a_out(b_fpu_a), .fpu_op_b_out(b_fpu_b),
    .fpu_data_in(b_fpu_data), .fpu_status_in(b_fpu_status), .fpu_flags_in(b_fpu_flags),
    .busy_out(b_busy), .grant_id_out(b_gid)
  );

  // fpu stand-in: 1.0+2.0 is exact, anything else returns a xor pattern
  function automatic logic [36:0] fpu_f(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) d = 32'h4040_0000;
    else                                          d = a ^ b;
    return {a[0] ^ b[0], a[3:0] ^ b[3:0], d};
  endfunction

  // Output becomes the new result only after operands have been stable L edges
  logic [36:0] pipe [0:L-2];
  always @(posedge clk) begin
    pipe[0] <= fpu_f(fpu_a, fpu_b);
    for (int i = 1; i < L - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign {fpu_flags, fpu_status, fpu_data}       = pipe[L-2];
  assign {b_fpu_flags, b_fpu_status, b_fpu_data} = fpu_f(b_fpu_a, b_fpu_b);

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 2'b00; op_a = '0; op_b = '0;
    b_req_valid = '0; b_rsp_ready = '0; b_op_a = '0; b_op_b = '0;
    @(posedge clk); @(posedge clk); @(negedge clk); #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else pass_cnt++;
    total++; if (rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); else pass_cnt++;
    total++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready: got %b want 00", req_ready); else pass_cnt++;
    total++; if ({gid, fpu_a, rsp_data} !== 65'd0) $display("FAIL reset_regs: gid=%0d fpu_a=%h rsp_data=%h want 0", gid, fpu_a, rsp_data); else pass_cnt++;
    req_valid = '0; rst_n = 1'b1;
  endtask

  task automatic test_single();
    int n;
    op_a[31:0] = 32'h3F80_0000; op_b[31:0] = 32'h4000_0000;
    req_valid = 2'b01; rsp_ready = 2'b01; #1;
    total++; if (req_ready !== 2'b01) $display("FAIL single_ready: got %b want 01", req_ready); else pass_cnt++;
    @(posedge clk); @(negedge clk); req_valid = '0; #1;
    total++; if ({busy, gid, fpu_a, fpu_b} !== {1'b1, 1'b0, 32'h3F80_0000, 32'h4000_0000})
      $display("FAIL single_wait: busy=%0b gid=%0d a=%h b=%h want 1 0 3f800000 40000000", busy, gid, fpu_a, fpu_b);
    else pass_cnt++;
    n = 0;
    while (rsp_valid == 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
    total++; if (n !== L) $display("FAIL single_latency: got %0d want %0d", n, L); else pass_cnt++;
    total++; if (rsp_valid !== 2'b01) $display("FAIL single_rsp_valid: got %b want 01", rsp_valid); else pass_cnt++;
    total++; if ({rsp_flags, rsp_status, rsp_data} !== {1'b0, 4'h0, 32'h4040_0000})
      $display("FAIL single_data: got %0b %h %h want 0 0 40400000", rsp_flags, rsp_status, rsp_data);
    else pass_cnt++;
    @(negedge clk); #1;
    total++; if ({busy, rsp_valid, fpu_a} !== {1'b0, 2'b00, 32'h3F80_0000})
      $display("FAIL single_done: busy=%0b rsp_valid=%b fpu_a=%h want 0 00 3f800000", busy, rsp_valid, fpu_a);
    else pass_cnt++;
  endtask

  task automatic test_stall_pending();
    int n;
    logic saw_ready;
    op_a = {32'hAAAA_0001, 32'h1234_5678}; op_b = {32'h5555_000C, 32'h0F0F_0F0F};
    req_valid = 2'b01; rsp_ready = 2'b00;
    @(posedge clk); @(negedge clk); req_valid = 2'b10; #1;
    n = 0; saw_ready = 1'b0;
    while (rsp_valid == 2'b00 && n < 20) begin
      if (req_ready !== 2'b00) saw_ready = 1'b1;
      @(negedge clk); #1; n++;
    end
    total++; if (saw_ready !== 1'b0) $display("FAIL pend_ready_in_wait: got 1 want 0"); else pass_cnt++;
    total++; if (n !== L) $display("FAIL stall_latency: got %0d want %0d", n, L); else pass_cnt++;
    rsp_ready = 2'b10;  // wrong requester's ready must be ignored
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({rsp_valid, rsp_flags, rsp_status, rsp_data, busy, req_ready} !== {2'b01, 1'b1, 4'h7, 32'h1D3B_5977, 1'b1, 2'b00})
        $display("FAIL stall_hold[%0d]: v=%b f=%0b s=%h d=%h busy=%0b rdy=%b want 01 1 7 1d3b5977 1 00",
                 k, rsp_valid, rsp_flags, rsp_status, rsp_data, busy, req_ready);
      else pass_cnt++;
      @(negedge clk); #1;
    end
    rsp_ready = 2'b01;
    @(negedge clk); #1;
    total++; if ({req_ready, rsp_valid} !== {2'b10, 2'b00})
      $display("FAIL pend_ready_idle: rdy=%b v=%b want 10 00", req_ready, rsp_valid);
    else pass_cnt++;
    @(posedge clk); @(negedge clk); req_valid = '0; rsp_ready = 2'b11; #1;
    n = 0;
    while (rsp_valid == 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
    total++;
    if ({gid, rsp_valid, rsp_flags, rsp_status, rsp_data} !== {1'b1, 2'b10, 1'b1, 4'hD, 32'hFFFF_000D})
      $display("FAIL req1_result: gid=%0d v=%b f=%0b s=%h d=%h want 1 10 1 d ffff000d",
               gid, rsp_valid, rsp_flags, rsp_status, rsp_data);
    else pass_cnt++;
    @(negedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int n;
    logic exp_g;
    rst_n = 1'b0; @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11; #1;
    for (int g = 0; g < 4; g++) begin
`ifdef FPU_SCHED_ROUND_ROBIN_EN
      exp_g = (g % 2 == 1);
`else
      exp_g = 1'b0;
`endif
      n = 0;
      while (req_ready == 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
      if (g > 0) begin
        total++; if (n !== L + 1) $display("FAIL b2b_gap[%0d]: got %0d want %0d", g, n, L + 1); else pass_cnt++;
      end
      total++;
      if (req_ready !== (exp_g ? 2'b10 : 2'b01))
        $display("FAIL b2b_grant[%0d]: got %b want %b", g, req_ready, exp_g ? 2'b10 : 2'b01);
      else pass_cnt++;
      @(posedge clk); @(negedge clk); #1;
    end
    req_valid = '0;
    n = 0;
    while (busy && n < 20) begin @(negedge clk); #1; n++; end
  endtask

  task automatic test_reset_mid();
    int n;
    logic saw_valid;
    req_valid = 2'b01; rsp_ready = 2'b11;
    @(posedge clk); @(negedge clk); req_valid = '0;
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk); #1;
    total++; if ({busy, rsp_valid, fpu_a, gid} !== {1'b0, 2'b00, 32'h0, 1'b0})
      $display("FAIL mid_reset: busy=%0b v=%b fpu_a=%h gid=%0d want 0 00 0 0", busy, rsp_valid, fpu_a, gid);
    else pass_cnt++;
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (n = 0; n < 8; n++) begin
      @(negedge clk); #1;
      if (rsp_valid !== 2'b00) saw_valid = 1'b1;
    end
    total++; if (saw_valid !== 1'b0) $display("FAIL mid_no_rsp: got 1 want 0"); else pass_cnt++;
  endtask

  task automatic test_lat1();
    int n;
    b_op_a = {32'h0, 32'h0000_0003}; b_op_b = {32'h0, 32'h0000_0005};
    b_req_valid = 2'b01; b_rsp_ready = 2'b01; #1;
    total++; if (b_req_ready !== 2'b01) $display("FAIL lat1_ready: got %b want 01", b_req_ready); else pass_cnt++;
    @(posedge clk); @(negedge clk); b_req_valid = '0; #1;
    n = 0;
    while (b_rsp_valid == 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
    total++; if (n !== 1) $display("FAIL lat1_latency: got %0d want 1", n); else pass_cnt++;
    total++; if ({b_rsp_valid, b_rsp_flags, b_rsp_status, b_rsp_data} !== {2'b01, 1'b0, 4'h6, 32'h6})
      $display("FAIL lat1_data: v=%b f=%0b s=%h d=%h want 01 0 6 00000006", b_rsp_valid, b_rsp_flags, b_rsp_status, b_rsp_data);
    else pass_cnt++;
    @(negedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall_pending();
    test_back_to_back();
    test_reset_mid();
    test_lat1();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

`default_nettype wire
